// File: rtl/ika2151_timer_regif.sv
// CPU bus register interface for the IKA2151 timer block: register decode, flag-reset
// pulses, write-busy counter, status readback and the CSM key-on strobe.
module ika2151_timer_regif #(
    parameter int BUSY_CYCLES = 64
) (
    input  logic       i_EMUCLK,
    input  logic       i_MRST_n,
    input  logic       i_phi1_NCEN_n,

    input  logic       i_CS_n,
    input  logic       i_WR_n,
    input  logic       i_RD_n,
    input  logic       i_A0,
    input  logic [7:0] i_D,
    output logic [7:0] o_D,
    output logic       o_D_OE,

    input  logic       i_TIMERA_FLAG,
    input  logic       i_TIMERB_FLAG,
    input  logic       i_TIMERA_OVFL,

    output logic [7:0] o_CLKA1,
    output logic [1:0] o_CLKA2,
    output logic [7:0] o_CLKB,
    output logic       o_TIMERA_FRST,
    output logic       o_TIMERB_FRST,
    output logic       o_TIMERA_RUN,
    output logic       o_TIMERB_RUN,
    output logic       o_TIMERA_IRQ_EN,
    output logic       o_TIMERB_IRQ_EN,
    output logic [7:0] o_TEST,
    output logic       o_CSM_KON
);

    localparam int CNT_W = $clog2(BUSY_CYCLES + 1);
    localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             tick;
    logic             wr;
    logic             wr_z;
    logic             wr_accept;
    logic             rd;
    logic             addr_wr;
    logic             data_wr;
    logic [7:0]       addr_reg;
    logic             csm_en;
    logic             busy;
    logic [CNT_W-1:0] busy_cnt;

    logic             sel_test;
    logic             sel_clka1;
    logic             sel_clka2;
    logic             sel_clkb;
    logic             sel_ctrl;

    assign tick = ~i_phi1_NCEN_n;

    // Bus protocol: a write is taken once, on the edge where CS_n&WR_n first go low;
    // there is no ready/backpressure, so every such edge is an accept.
    assign wr        = ~i_CS_n & ~i_WR_n;
    assign rd        = ~i_CS_n & ~i_RD_n & i_WR_n;
    assign wr_accept = wr & ~wr_z;
    assign addr_wr   = wr_accept & ~i_A0;
    assign data_wr   = wr_accept &  i_A0;

    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            wr_z <= 1'b0;
        end else begin
            wr_z <= wr;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            addr_reg <= 8'h00;
        end else if (addr_wr) begin
            addr_reg <= i_D;
        end
    end

    always_comb begin
        sel_test  = 1'b0;
        sel_clka1 = 1'b0;
        sel_clka2 = 1'b0;
        sel_clkb  = 1'b0;
        sel_ctrl  = 1'b0;
        if (data_wr) begin
            case (addr_reg)
                8'h01:   sel_test  = 1'b1;
                8'h10:   sel_clka1 = 1'b1;
                8'h11:   sel_clka2 = 1'b1;
                8'h12:   sel_clkb  = 1'b1;
                8'h14:   sel_ctrl  = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            o_TEST  <= 8'h00;
            o_CLKA1 <= 8'h00;
            o_CLKA2 <= 2'b00;
            o_CLKB  <= 8'h00;
        end else begin
            if (sel_test)  o_TEST  <= i_D;
            if (sel_clka1) o_CLKA1 <= i_D;
            if (sel_clka2) o_CLKA2 <= i_D[1:0];
            if (sel_clkb)  o_CLKB  <= i_D;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            csm_en          <= 1'b0;
            o_TIMERB_IRQ_EN <= 1'b0;
            o_TIMERA_IRQ_EN <= 1'b0;
            o_TIMERB_RUN    <= 1'b0;
            o_TIMERA_RUN    <= 1'b0;
        end else if (sel_ctrl) begin
            csm_en          <= i_D[7];
            o_TIMERB_IRQ_EN <= i_D[3];
            o_TIMERA_IRQ_EN <= i_D[2];
            o_TIMERB_RUN    <= i_D[1];
            o_TIMERA_RUN    <= i_D[0];
        end
    end

    // Set wins over the tick clear, so the pulse always survives until the next tick.
    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            o_TIMERA_FRST <= 1'b0;
        end else if (sel_ctrl && i_D[4]) begin
            o_TIMERA_FRST <= 1'b1;
        end else if (tick) begin
            o_TIMERA_FRST <= 1'b0;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            o_TIMERB_FRST <= 1'b0;
        end else if (sel_ctrl && i_D[5]) begin
            o_TIMERB_FRST <= 1'b1;
        end else if (tick) begin
            o_TIMERB_FRST <= 1'b0;
        end
    end

    // Any data write (listed address or not) restarts the busy window.
    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            busy     <= 1'b0;
            busy_cnt <= '0;
        end else if (data_wr) begin
            busy     <= 1'b1;
            busy_cnt <= BUSY_LOAD;
        end else if (tick && busy) begin
            busy_cnt <= busy_cnt - CNT_ONE;
            if (busy_cnt == CNT_ONE) begin
                busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            o_D    <= 8'h00;
            o_D_OE <= 1'b0;
        end else begin
            o_D    <= {busy, 5'b00000, i_TIMERB_FLAG, i_TIMERA_FLAG};
            o_D_OE <= rd;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            o_CSM_KON <= 1'b0;
        end else if (tick) begin
            o_CSM_KON <= csm_en & i_TIMERA_OVFL;
        end
    end

endmodule

// File: tb/tb_ika2151_timer_regif.sv
// Directed bench for ika2151_timer_regif: status reads go through an expected-value
// queue checked by a monitor; register outputs are checked directly after each accept.
module tb_ika2151_timer_regif;

    logic       i_EMUCLK = 1'b0;
    logic       i_MRST_n;
    logic       i_phi1_NCEN_n;
    logic       i_CS_n;
    logic       i_WR_n;
    logic       i_RD_n;
    logic       i_A0;
    logic [7:0] i_D;
    logic [7:0] o_D;
    logic       o_D_OE;
    logic       i_TIMERA_FLAG;
    logic       i_TIMERB_FLAG;
    logic       i_TIMERA_OVFL;
    logic [7:0] o_CLKA1;
    logic [1:0] o_CLKA2;
    logic [7:0] o_CLKB;
    logic       o_TIMERA_FRST;
    logic       o_TIMERB_FRST;
    logic       o_TIMERA_RUN;
    logic       o_TIMERB_RUN;
    logic       o_TIMERA_IRQ_EN;
    logic       o_TIMERB_IRQ_EN;
    logic [7:0] o_TEST;
    logic       o_CSM_KON;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] exp_q[$];

    ika2151_timer_regif dut (
        .i_EMUCLK        (i_EMUCLK),
        .i_MRST_n        (i_MRST_n),
        .i_phi1_NCEN_n   (i_phi1_NCEN_n),
        .i_CS_n          (i_CS_n),
        .i_WR_n          (i_WR_n),
        .i_RD_n          (i_RD_n),
        .i_A0            (i_A0),
        .i_D             (i_D),
        .o_D             (o_D),
        .o_D_OE          (o_D_OE),
        .i_TIMERA_FLAG   (i_TIMERA_FLAG),
        .i_TIMERB_FLAG   (i_TIMERB_FLAG),
        .i_TIMERA_OVFL   (i_TIMERA_OVFL),
        .o_CLKA1         (o_CLKA1),
        .o_CLKA2         (o_CLKA2),
        .o_CLKB          (o_CLKB),
        .o_TIMERA_FRST   (o_TIMERA_FRST),
        .o_TIMERB_FRST   (o_TIMERB_FRST),
        .o_TIMERA_RUN    (o_TIMERA_RUN),
        .o_TIMERB_RUN    (o_TIMERB_RUN),
        .o_TIMERA_IRQ_EN (o_TIMERA_IRQ_EN),
        .o_TIMERB_IRQ_EN (o_TIMERB_IRQ_EN),
        .o_TEST          (o_TEST),
        .o_CSM_KON       (o_CSM_KON)
    );

    // Clock and watchdog
    always #5 i_EMUCLK = ~i_EMUCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Read-data monitor: every cycle the DUT presents o_D_OE, one expected value is consumed
    always @(negedge i_EMUCLK) begin
        if (o_D_OE === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL read_unexpected: got o_D_OE=1 o_D=0x%02h, required no read", o_D);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (o_D === e) n_pass++;
                else $display("FAIL read_status: got 0x%02h required 0x%02h", o_D, e);
            end
        end
    end

    // Driver tasks
    task automatic cyc();
        @(posedge i_EMUCLK);
        #1;
    endtask

    task automatic bus_idle();
        i_CS_n = 1'b1;
        i_WR_n = 1'b1;
        i_RD_n = 1'b1;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h required 0x%02h", name, act, exp);
    endtask

    // Returns just after the accepting edge; strobes are released but no edge has passed.
    task automatic bus_write(input logic a0, input logic [7:0] d);
        bus_idle();
        cyc();
        i_CS_n = 1'b0;
        i_WR_n = 1'b0;
        i_A0   = a0;
        i_D    = d;
        cyc();
        bus_idle();
    endtask

    task automatic reg_write(input logic [7:0] addr, input logic [7:0] data);
        bus_write(1'b0, addr);
        bus_write(1'b1, data);
    endtask

    task automatic read_status(input logic [7:0] exp);
        i_CS_n = 1'b0;
        i_RD_n = 1'b0;
        i_WR_n = 1'b1;
        exp_q.push_back(exp);
        cyc();
        bus_idle();
    endtask

    // A data write is held on the bus during reset; reset must win.
    task automatic do_reset();
        i_MRST_n = 1'b0;
        i_CS_n   = 1'b0;
        i_WR_n   = 1'b0;
        i_RD_n   = 1'b1;
        i_A0     = 1'b1;
        i_D      = 8'hFF;
        cyc();
        cyc();
        i_MRST_n = 1'b1;
        bus_idle();
        i_A0     = 1'b0;
    endtask

    task automatic read_burst(input int k_first, input int k_last, input int busy_last);
        i_CS_n = 1'b0;
        i_RD_n = 1'b0;
        i_WR_n = 1'b1;
        for (int k = k_first; k <= k_last; k++) begin
            exp_q.push_back((k <= busy_last) ? 8'h80 : 8'h00);
            cyc();
        end
        bus_idle();
    endtask

    initial begin
        int a_cnt;
        int b_cnt;
        i_MRST_n      = 1'b0;
        i_phi1_NCEN_n = 1'b1;
        i_A0          = 1'b0;
        i_D           = 8'h00;
        i_TIMERA_FLAG = 1'b0;
        i_TIMERB_FLAG = 1'b0;
        i_TIMERA_OVFL = 1'b0;
        bus_idle();

        // Reset state
        do_reset();
        check8("rst_clka1", o_CLKA1, 8'h00);
        check8("rst_clka2", {6'b0, o_CLKA2}, 8'h00);
        check8("rst_clkb", o_CLKB, 8'h00);
        check8("rst_test", o_TEST, 8'h00);
        check8("rst_ctrl", {2'b0, o_TIMERA_FRST, o_TIMERB_FRST, o_TIMERA_RUN, o_TIMERB_RUN,
                            o_TIMERA_IRQ_EN, o_TIMERB_IRQ_EN}, 8'h00);
        check8("rst_kon_oe", {6'b0, o_CSM_KON, o_D_OE}, 8'h00);
        read_status(8'h00);
        i_TIMERA_FLAG = 1'b1;
        i_TIMERB_FLAG = 1'b1;
        read_status(8'h03);
        i_TIMERA_FLAG = 1'b0;
        read_status(8'h02);
        i_TIMERB_FLAG = 1'b0;
        cyc();
        check8("oe_after_read", {7'b0, o_D_OE}, 8'h00);

        // Register writes
        reg_write(8'h01, 8'h5A);
        check8("test_reg", o_TEST, 8'h5A);
        reg_write(8'h10, 8'hA5);
        check8("clka1", o_CLKA1, 8'hA5);
        reg_write(8'h11, 8'hFE);
        check8("clka2", {6'b0, o_CLKA2}, 8'h02);
        check8("clka1_kept", o_CLKA1, 8'hA5);
        reg_write(8'h12, 8'h3C);
        check8("clkb", o_CLKB, 8'h3C);
        bus_write(1'b1, 8'h77);
        check8("clkb_no_autoinc", o_CLKB, 8'h77);
        reg_write(8'h13, 8'hEE);
        check8("unlisted_clkb", o_CLKB, 8'h77);
        check8("unlisted_test", o_TEST, 8'h5A);
        bus_write(1'b0, 8'h10);
        cyc();
        i_CS_n = 1'b0;
        i_WR_n = 1'b0;
        i_A0   = 1'b1;
        i_D    = 8'hC3;
        check8("clka1_pre_edge", o_CLKA1, 8'hA5);
        cyc();
        bus_idle();
        check8("clka1_post_edge", o_CLKA1, 8'hC3);

        // Control byte and FRST pulses
        reg_write(8'h14, 8'h3F);
        check8("ctrl_3f", {4'b0, o_TIMERA_RUN, o_TIMERB_RUN, o_TIMERA_IRQ_EN, o_TIMERB_IRQ_EN}, 8'h0F);
        check8("frst_set", {6'b0, o_TIMERA_FRST, o_TIMERB_FRST}, 8'h03);
        cyc();
        cyc();
        cyc();
        check8("frst_hold_no_tick", {6'b0, o_TIMERA_FRST, o_TIMERB_FRST}, 8'h03);
        a_cnt = 0;
        b_cnt = 0;
        i_phi1_NCEN_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (o_TIMERA_FRST) a_cnt++;
            if (o_TIMERB_FRST) b_cnt++;
            cyc();
        end
        i_phi1_NCEN_n = 1'b1;
        check8("frst_a_ticks", 8'(a_cnt), 8'h01);
        check8("frst_b_ticks", 8'(b_cnt), 8'h01);
        check8("frst_clear", {6'b0, o_TIMERA_FRST, o_TIMERB_FRST}, 8'h00);
        reg_write(8'h14, 8'h04);
        check8("ctrl_04", {4'b0, o_TIMERA_RUN, o_TIMERB_RUN, o_TIMERA_IRQ_EN, o_TIMERB_IRQ_EN}, 8'h02);

        // Busy window, one tick per clock
        do_reset();
        i_phi1_NCEN_n = 1'b0;
        bus_write(1'b0, 8'h20);
        read_status(8'h00);
        bus_write(1'b1, 8'h55);
        read_burst(1, 70, 64);

        bus_write(1'b1, 8'h66);
        read_burst(1, 29, 200);
        i_CS_n = 1'b0;
        i_RD_n = 1'b0;
        i_WR_n = 1'b0;
        i_A0   = 1'b1;
        cyc();
        check8("oe_wr_rd_both_low", {7'b0, o_D_OE}, 8'h00);
        read_burst(31, 100, 94);

        // Strobe held low for 20 edges: a single accept
        i_CS_n = 1'b0;
        i_WR_n = 1'b0;
        i_A0   = 1'b1;
        i_D    = 8'h11;
        for (int i = 0; i < 20; i++) cyc();
        read_burst(20, 70, 64);

        // Reset mid-busy and mid-FRST
        bus_write(1'b1, 8'h22);
        cyc();
        cyc();
        do_reset();
        read_status(8'h00);
        i_phi1_NCEN_n = 1'b1;
        reg_write(8'h12, 8'h99);
        reg_write(8'h14, 8'h30);
        check8("frst_before_rst", {6'b0, o_TIMERA_FRST, o_TIMERB_FRST}, 8'h03);
        do_reset();
        check8("frst_after_rst", {6'b0, o_TIMERA_FRST, o_TIMERB_FRST}, 8'h00);
        check8("clkb_after_rst", o_CLKB, 8'h00);
        read_status(8'h00);

        // CSM key-on
        reg_write(8'h14, 8'h81);
        i_TIMERA_OVFL = 1'b1;
        cyc();
        check8("csm_no_tick", {7'b0, o_CSM_KON}, 8'h00);
        i_phi1_NCEN_n = 1'b0;
        cyc();
        check8("csm_kon", {7'b0, o_CSM_KON}, 8'h01);
        i_TIMERA_OVFL = 1'b0;
        cyc();
        check8("csm_one_tick", {7'b0, o_CSM_KON}, 8'h00);
        i_phi1_NCEN_n = 1'b1;
        reg_write(8'h14, 8'h01);
        i_TIMERA_OVFL = 1'b1;
        i_phi1_NCEN_n = 1'b0;
        cyc();
        check8("csm_disabled", {7'b0, o_CSM_KON}, 8'h00);
        i_TIMERA_OVFL = 1'b0;
        cyc();
        i_phi1_NCEN_n = 1'b1;

        // Report
        cyc();
        cyc();
        check8("read_queue_drain", 8'(exp_q.size()), 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
